// File: rtl/cr_cddip_sa_multi_pkg.sv
// Shared constants and types for the stats-aggregator counter core.
package cr_cddip_sa_multi_pkg;

  localparam int SA_N_CNTRS  = 64;
  localparam int SA_CNT_W    = 50;
  localparam int SA_N_EVENTS = 256;

  typedef enum logic {
    SA_RD_LIVE = 1'b0,
    SA_RD_SNAP = 1'b1
  } sa_rd_src_e;

endpackage

// File: rtl/cr_cddip_sa_cntr.sv
// One stats counter: live count with saturate/wrap, snapshot copy and sticky overflow.
module cr_cddip_sa_cntr
  import cr_cddip_sa_multi_pkg::*;
#(
  parameter int CNT_W = SA_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             sat,
  input  logic             snap,
  input  logic             clear_live,
  input  logic             rd_clr,
  output logic [CNT_W-1:0] live,
  output logic [CNT_W-1:0] snapshot,
  output logic             ovf
);

  logic             at_max;
  logic [CNT_W-1:0] live_inc;

  assign at_max   = &live;
  assign live_inc = at_max ? (sat ? live : '0) : live + CNT_W'(1);

  // Global clear beats read-clear; a read-clear keeps a coincident event as a count of one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live     <= '0;
      snapshot <= '0;
      ovf      <= 1'b0;
    end else begin
      if (snap) snapshot <= live;
      if (clear_live) begin
        live <= '0;
        ovf  <= 1'b0;
      end else if (rd_clr) begin
        live <= inc ? CNT_W'(1) : '0;
        ovf  <= 1'b0;
      end else if (inc) begin
        live <= live_inc;
        if (at_max) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr_cddip_sa_multi.sv
// Stats-aggregator core: per-counter event select, snapshot/clear and a one-cycle indexed read port.
module cr_cddip_sa_multi
  import cr_cddip_sa_multi_pkg::*;
#(
  parameter int N_CNTRS  = SA_N_CNTRS,
  parameter int CNT_W    = SA_CNT_W,
  parameter int N_EVENTS = SA_N_EVENTS,
  parameter int SEL_W    = $clog2(N_EVENTS),
  parameter int IDX_W    = $clog2(N_CNTRS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_EVENTS-1:0]      stat_events,
  input  logic [N_CNTRS-1:0]       cfg_en,
  input  logic [N_CNTRS*SEL_W-1:0] cfg_sel,
  input  logic [N_CNTRS-1:0]       cfg_sat,
  input  logic                     regs_sa_snap,
  input  logic                     regs_sa_clear_live,
  input  logic                     rd_req,
  input  logic [IDX_W-1:0]         rd_idx,
  input  logic                     rd_snap,
  input  logic                     rd_clr,
  output logic                     rd_ack,
  output logic [CNT_W-1:0]         rd_data,
  output logic                     rd_ovf,
  output logic                     sa_ovf_any
);

  logic [N_EVENTS-1:0] ev_e1;
  logic [N_CNTRS-1:0]  inc;
  logic [N_CNTRS-1:0]  rd_clr_hit;
  logic [N_CNTRS-1:0]  ovf;
  logic [CNT_W-1:0]    live     [N_CNTRS];
  logic [CNT_W-1:0]    snapshot [N_CNTRS];
  sa_rd_src_e          rd_src;
  logic                idx_ok;
  logic [CNT_W-1:0]    rd_val;
  logic                rd_ovf_val;

  always_ff @(posedge clk) begin
    if (!rst_n) ev_e1 <= '0;
    else        ev_e1 <= stat_events;
  end

  assign rd_src = sa_rd_src_e'(rd_snap);
  assign idx_ok = {1'b0, rd_idx} < (IDX_W+1)'(N_CNTRS);

  for (genvar g = 0; g < N_CNTRS; g++) begin : g_cntr
    logic [SEL_W-1:0] sel;
    logic             sel_ok;

    // Select values past the end of the event bus are a valid "count nothing" setting.
    assign sel    = cfg_sel[g*SEL_W +: SEL_W];
    assign sel_ok = {1'b0, sel} < (SEL_W+1)'(N_EVENTS);
    assign inc[g] = cfg_en[g] & sel_ok & ev_e1[sel];
    assign rd_clr_hit[g] = rd_req & rd_clr & (rd_src == SA_RD_LIVE) & (rd_idx == IDX_W'(g));

    cr_cddip_sa_cntr #(.CNT_W(CNT_W)) u_cntr (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (inc[g]),
      .sat        (cfg_sat[g]),
      .snap       (regs_sa_snap),
      .clear_live (regs_sa_clear_live),
      .rd_clr     (rd_clr_hit[g]),
      .live       (live[g]),
      .snapshot   (snapshot[g]),
      .ovf        (ovf[g])
    );
  end

  always_comb begin
    rd_val     = '0;
    rd_ovf_val = 1'b0;
    if (idx_ok) begin
      rd_val     = (rd_src == SA_RD_SNAP) ? snapshot[rd_idx] : live[rd_idx];
      rd_ovf_val = ovf[rd_idx];
    end
  end

  // Read data is captured only on a request so it holds until the next acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ack     <= 1'b0;
      rd_data    <= '0;
      rd_ovf     <= 1'b0;
      sa_ovf_any <= 1'b0;
    end else begin
      rd_ack     <= rd_req;
      sa_ovf_any <= |ovf;
      if (rd_req) begin
        rd_data <= rd_val;
        rd_ovf  <= rd_ovf_val;
      end
    end
  end

endmodule

// File: tb/tb_cr_cddip_sa_multi.sv
// Self-checking bench for cr_cddip_sa_multi: directed scenarios plus a random phase against a count model.
module tb_cr_cddip_sa_multi;

  localparam int NC = 6;
  localparam int CW = 8;
  localparam int NE = 24;
  localparam int SW = $clog2(NE);
  localparam int IW = $clog2(NC);
  localparam longint unsigned MAXV = (64'd1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NE-1:0]     stat_events = '0;
  logic [NC-1:0]     cfg_en = '0;
  logic [NC*SW-1:0]  cfg_sel = '0;
  logic [NC-1:0]     cfg_sat = '0;
  logic              regs_sa_snap = 1'b0;
  logic              regs_sa_clear_live = 1'b0;
  logic              rd_req = 1'b0;
  logic [IW-1:0]     rd_idx = '0;
  logic              rd_snap = 1'b0;
  logic              rd_clr = 1'b0;
  logic              rd_ack;
  logic [CW-1:0]     rd_data;
  logic              rd_ovf;
  logic              sa_ovf_any;

  int errors = 0;
  int checks = 0;
  string phase = "init";

  longint unsigned m_live [NC];
  longint unsigned m_snap [NC];
  bit              m_ovf  [NC];
  logic [NE-1:0]   m_e1;
  bit              e_ack, e_ovf, e_any;
  longint unsigned e_data;

  cr_cddip_sa_multi #(.N_CNTRS(NC), .CNT_W(CW), .N_EVENTS(NE)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stat_events        (stat_events),
    .cfg_en             (cfg_en),
    .cfg_sel            (cfg_sel),
    .cfg_sat            (cfg_sat),
    .regs_sa_snap       (regs_sa_snap),
    .regs_sa_clear_live (regs_sa_clear_live),
    .rd_req             (rd_req),
    .rd_idx             (rd_idx),
    .rd_snap            (rd_snap),
    .rd_clr             (rd_clr),
    .rd_ack             (rd_ack),
    .rd_data            (rd_data),
    .rd_ovf             (rd_ovf),
    .sa_ovf_any         (sa_ovf_any)
  );

  always #5 clk = ~clk;

  // Reference behaviour for one rising edge, computed from the current inputs and model state.
  task automatic model_edge();
    longint unsigned old_live [NC];
    bit inc_v [NC];
    bit any_old;
    int sel;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        m_live[i] = 0; m_snap[i] = 0; m_ovf[i] = 0;
      end
      m_e1 = '0; e_ack = 0; e_data = 0; e_ovf = 0; e_any = 0;
      return;
    end
    any_old = 0;
    for (int i = 0; i < NC; i++) begin
      old_live[i] = m_live[i];
      any_old |= m_ovf[i];
      sel = int'(cfg_sel[i*SW +: SW]);
      inc_v[i] = cfg_en[i] && (sel < NE) && m_e1[sel];
    end
    e_ack = rd_req;
    if (rd_req) begin
      if (int'(rd_idx) < NC) begin
        e_data = rd_snap ? m_snap[rd_idx] : m_live[rd_idx];
        e_ovf  = m_ovf[rd_idx];
      end else begin
        e_data = 0;
        e_ovf  = 0;
      end
    end
    e_any = any_old;
    for (int i = 0; i < NC; i++) begin
      if (regs_sa_snap) m_snap[i] = old_live[i];
      if (regs_sa_clear_live) begin
        m_live[i] = 0; m_ovf[i] = 0;
      end else if (rd_req && rd_clr && !rd_snap && int'(rd_idx) == i) begin
        m_live[i] = inc_v[i] ? 1 : 0; m_ovf[i] = 0;
      end else if (inc_v[i]) begin
        if (old_live[i] == MAXV) begin
          m_ovf[i]  = 1;
          m_live[i] = cfg_sat[i] ? MAXV : 0;
        end else begin
          m_live[i] = old_live[i] + 1;
        end
      end
    end
    m_e1 = stat_events;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s/%s: observed %0d, expected %0d", phase, tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs are compared at the following falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    checkOutput("rd_ack", 64'(rd_ack), 64'(e_ack));
    checkOutput("rd_data", 64'(rd_data), e_data);
    checkOutput("rd_ovf", 64'(rd_ovf), 64'(e_ovf));
    checkOutput("sa_ovf_any", 64'(sa_ovf_any), 64'(e_any));
  endtask

  task automatic do_read(input int idx, input bit snap, input bit clr);
    rd_req = 1'b1; rd_idx = IW'(idx); rd_snap = snap; rd_clr = clr;
    applyStimulus();
    rd_req = 1'b0; rd_snap = 1'b0; rd_clr = 1'b0;
  endtask

  task automatic pulse_clear();
    regs_sa_clear_live = 1'b1;
    applyStimulus();
    regs_sa_clear_live = 1'b0;
  endtask

  initial begin
    phase = "reset";
    stat_events = '1; regs_sa_snap = 1'b1; rd_req = 1'b1; cfg_en = '1;
    repeat (4) applyStimulus();
    stat_events = '0; regs_sa_snap = 1'b0; rd_req = 1'b0; cfg_en = '0;
    rst_n = 1'b1;
    applyStimulus();
    do_read(3, 1'b0, 1'b0);
    checkOutput("cnt3_after_reset", 64'(rd_data), 64'd0);

    phase = "latency";
    cfg_en[3] = 1'b1; cfg_sel[3*SW +: SW] = SW'(17);
    cfg_en[4] = 1'b1; cfg_sel[4*SW +: SW] = SW'(30);
    stat_events = '1;
    repeat (5) applyStimulus();
    stat_events = '0;
    do_read(3, 1'b0, 1'b0);
    checkOutput("cnt3_one_edge_early", 64'(rd_data), 64'd4);
    do_read(3, 1'b0, 1'b0);
    checkOutput("cnt3_final", 64'(rd_data), 64'd5);
    do_read(4, 1'b0, 1'b0);
    checkOutput("cnt4_sel_out_of_range", 64'(rd_data), 64'd0);

    phase = "overflow";
    cfg_en[0] = 1'b1; cfg_sat[0] = 1'b1;
    cfg_en[1] = 1'b1; cfg_sat[1] = 1'b0;
    pulse_clear();
    stat_events = NE'(1);
    repeat (255) applyStimulus();
    stat_events = '0;
    applyStimulus();
    do_read(0, 1'b0, 1'b0);
    checkOutput("cnt0_full", 64'(rd_data), 64'd255);
    checkOutput("cnt0_full_ovf", 64'(rd_ovf), 64'd0);
    stat_events = NE'(1);
    applyStimulus();
    stat_events = '0;
    applyStimulus();
    do_read(0, 1'b0, 1'b0);
    checkOutput("cnt0_saturated", 64'(rd_data), 64'd255);
    checkOutput("cnt0_sat_ovf", 64'(rd_ovf), 64'd1);
    do_read(1, 1'b0, 1'b0);
    checkOutput("cnt1_wrapped", 64'(rd_data), 64'd0);
    checkOutput("cnt1_wrap_ovf", 64'(rd_ovf), 64'd1);
    checkOutput("ovf_any_set", 64'(sa_ovf_any), 64'd1);
    pulse_clear();
    applyStimulus();
    checkOutput("ovf_any_cleared", 64'(sa_ovf_any), 64'd0);
    do_read(0, 1'b0, 1'b0);
    checkOutput("cnt0_ovf_cleared", 64'(rd_ovf), 64'd0);

    phase = "snap_clear";
    pulse_clear();
    stat_events = NE'(1);
    repeat (43) applyStimulus();
    stat_events = '0;
    regs_sa_snap = 1'b1; regs_sa_clear_live = 1'b1;
    applyStimulus();
    regs_sa_snap = 1'b0; regs_sa_clear_live = 1'b0;
    do_read(0, 1'b1, 1'b0);
    checkOutput("snap0", 64'(rd_data), 64'd42);
    do_read(0, 1'b0, 1'b0);
    checkOutput("live0_cleared", 64'(rd_data), 64'd0);

    phase = "read_clear";
    cfg_en[2] = 1'b1; cfg_sel[2*SW +: SW] = SW'(5);
    pulse_clear();
    stat_events = NE'(1) << 5;
    repeat (10) applyStimulus();
    stat_events = '0;
    do_read(2, 1'b0, 1'b1);
    checkOutput("rdclr_returned", 64'(rd_data), 64'd9);
    do_read(2, 1'b0, 1'b0);
    checkOutput("rdclr_kept_event", 64'(rd_data), 64'd1);

    phase = "b2b_reads";
    for (int i = 0; i <= NC + 1; i++) begin
      rd_req = 1'b1; rd_idx = IW'(i); rd_snap = i[0];
      applyStimulus();
      checkOutput("b2b_ack", 64'(rd_ack), 64'd1);
      if (i >= NC) begin
        checkOutput("oob_data", 64'(rd_data), 64'd0);
        checkOutput("oob_ovf", 64'(rd_ovf), 64'd0);
      end
    end
    rst_n = 1'b0;
    applyStimulus();
    checkOutput("reset_drops_read", 64'(rd_ack), 64'd0);
    rd_req = 1'b0; rst_n = 1'b1;
    applyStimulus();

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        cfg_en  = NC'($urandom);
        cfg_sat = NC'($urandom);
        for (int i = 0; i < NC; i++) cfg_sel[i*SW +: SW] = SW'($urandom_range(0, 31));
      end
      stat_events        = NE'($urandom);
      regs_sa_snap       = ($urandom_range(0, 15) == 0);
      regs_sa_clear_live = ($urandom_range(0, 63) == 0);
      rd_req             = $urandom_range(0, 1) != 0;
      rd_idx             = IW'($urandom_range(0, 7));
      rd_snap            = $urandom_range(0, 1) != 0;
      rd_clr             = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end
    stat_events = '0; regs_sa_snap = 1'b0; regs_sa_clear_live = 1'b0;
    rd_req = 1'b0; rd_clr = 1'b0;
    for (int i = 0; i < NC; i++) do_read(i, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
